// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, signed or
// unsigned operands selected per operation, exact 2*WIDTH-bit product.
module booth_radix4_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tc,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           state_dbg
);

  // Handshake: start is sampled only while busy=0 (IDLE); the rising edge with
  // start=1 and busy=0 accepts tc/a/b. done is a one-cycle pulse marking product
  // valid; product then holds until the next operation completes or reset.

  localparam int XW = WIDTH + 2;
  localparam int HW = WIDTH + 4;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam logic [CW-1:0] LAST_SIGNED   = CW'(WIDTH / 2 - 1);
  localparam logic [CW-1:0] LAST_UNSIGNED = CW'(WIDTH / 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XW-1:0]   mcand;
  logic [HW-1:0]   acc_hi;
  logic [XW-1:0]   acc_lo;
  logic            bm1;
  logic            tc_q;
  logic [CW-1:0]   cnt;

  logic            dig_single;
  logic            dig_double;
  logic            dig_negate;
  logic            neg_eff;
  logic [XW-1:0]   pp_mag;
  logic [XW-1:0]   pp_x;
  logic [HW-1:0]   sum;
  logic [HW-1:0]   hi_nxt;
  logic [XW-1:0]   lo_nxt;
  logic            last_digit;

  // Multiplier bits live in acc_lo and are consumed from the bottom as the
  // partial sum shifts in from acc_hi.
  always_comb begin
    dig_single = acc_lo[0] ^ bm1;
    dig_double = (acc_lo[1] & ~acc_lo[0] & ~bm1) | (~acc_lo[1] & acc_lo[0] & bm1);
    dig_negate = acc_lo[1];
    pp_mag     = '0;
    if (dig_single) begin
      pp_mag = mcand;
    end else if (dig_double) begin
      pp_mag = {mcand[XW-2:0], 1'b0};
    end
    // Triplet 111 selects zero: no inversion and no carry-in.
    neg_eff = dig_negate & (dig_single | dig_double);
    pp_x    = pp_mag ^ {XW{neg_eff}};
    sum     = acc_hi + {{(HW - XW){pp_x[XW-1]}}, pp_x} + {{(HW - 1){1'b0}}, neg_eff};
    hi_nxt  = {{2{sum[HW-1]}}, sum[HW-1:2]};
    lo_nxt  = {sum[1:0], acc_lo[XW-1:2]};
  end

  assign last_digit = (cnt == (tc_q ? LAST_SIGNED : LAST_UNSIGNED));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      bm1     <= 1'b0;
      tc_q    <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{2{tc & a[WIDTH-1]}}, a};
            acc_lo <= {{2{tc & b[WIDTH-1]}}, b};
            acc_hi <= '0;
            bm1    <= 1'b0;
            tc_q   <= tc;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc_hi <= hi_nxt;
          acc_lo <= lo_nxt;
          bm1    <= acc_lo[1];
          cnt    <= cnt + 1'b1;
          // Signed runs shift 2 bits fewer than unsigned, so the product window
          // sits 2 bits higher in {acc_hi, acc_lo}.
          if (last_digit) begin
            product <= tc_q ? {hi_nxt[WIDTH-1:0], lo_nxt[XW-1:2]}
                            : {hi_nxt[WIDTH-3:0], lo_nxt};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Directed bench for booth_radix4_mult at WIDTH 4, 8 and 16: latency, exact
// products, start-while-busy, held start through DONE, and async reset abort.
module tb_booth_radix4_mult;

  logic        clk;
  logic        reset;
  logic [2:0]  start_sel;
  logic        tc_in;
  logic [15:0] a_in;
  logic [15:0] b_in;

  logic        busy4, done4, busy8, done8, busy16, done16;
  logic [7:0]  prod4;
  logic [15:0] prod8;
  logic [31:0] prod16;
  logic [1:0]  st4, st8, st16;

  int tests = 0;
  int fails = 0;

  booth_radix4_mult #(.WIDTH(4)) u_w4 (
    .clk(clk), .reset(reset), .start(start_sel[0]), .tc(tc_in),
    .a(a_in[3:0]), .b(b_in[3:0]), .busy(busy4), .done(done4),
    .product(prod4), .state_dbg(st4)
  );

  booth_radix4_mult #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .start(start_sel[1]), .tc(tc_in),
    .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy8), .done(done8),
    .product(prod8), .state_dbg(st8)
  );

  booth_radix4_mult #(.WIDTH(16)) u_w16 (
    .clk(clk), .reset(reset), .start(start_sel[2]), .tc(tc_in),
    .a(a_in), .b(b_in), .busy(busy16), .done(done16),
    .product(prod16), .state_dbg(st16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic obs_done(input int w);
    case (w)
      4:       return done4;
      8:       return done8;
      default: return done16;
    endcase
  endfunction

  function automatic logic obs_busy(input int w);
    case (w)
      4:       return busy4;
      8:       return busy8;
      default: return busy16;
    endcase
  endfunction

  function automatic logic [31:0] obs_prod(input int w);
    case (w)
      4:       return {24'd0, prod4};
      8:       return {16'd0, prod8};
      default: return prod16;
    endcase
  endfunction

  function automatic logic [2:0] sel_of(input int w);
    case (w)
      4:       return 3'b001;
      8:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // reference: plain integer multiply of the w-bit operands, masked to 2w bits
  function automatic logic [31:0] ref_mult(input int w, input bit t,
                                           input logic [15:0] av, input logic [15:0] bv);
    longint     sa, sb, p;
    logic [15:0] am, bm;
    logic [63:0] pm, mask;
    am = av & 16'((32'd1 << w) - 1);
    bm = bv & 16'((32'd1 << w) - 1);
    sa = longint'(am);
    sb = longint'(bm);
    if (t && am[w-1]) sa = sa - (longint'(1) << w);
    if (t && bm[w-1]) sb = sb - (longint'(1) << w);
    p    = sa * sb;
    pm   = 64'(p);
    mask = (64'd1 << (2 * w)) - 64'd1;
    pm   = pm & mask;
    return pm[31:0];
  endfunction

  // driver: one full operation with latency, product, pulse and hold checks
  task automatic run_op(input int w, input bit t, input logic [15:0] av,
                        input logic [15:0] bv, input logic [31:0] exp, input string tag);
    int lat;
    int iter;
    iter = t ? w / 2 : w / 2 + 1;
    @(negedge clk);
    tc_in = t; a_in = av; b_in = bv; start_sel = sel_of(w);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_sel = 3'b000;
    chk({tag, " busy"}, {31'd0, obs_busy(w)}, 32'd1);
    while (obs_done(w) !== 1'b1 && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, 32'(lat), 32'(iter + 1));
    chk({tag, " product"}, obs_prod(w), exp);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " done pulse"}, {31'd0, obs_done(w)}, 32'd0);
    chk({tag, " idle"}, {31'd0, obs_busy(w)}, 32'd0);
    chk({tag, " hold"}, obs_prod(w), exp);
  endtask

  initial begin
    int  lat;
    bit  busy_ok;
    logic [15:0] ra, rb;
    int  widths[3];
    widths[0] = 4; widths[1] = 8; widths[2] = 16;

    reset = 1'b1; start_sel = 3'b000; tc_in = 1'b0; a_in = '0; b_in = '0;
    #1;
    chk("reset busy", {29'd0, busy4, busy8, busy16}, 32'd0);
    chk("reset done", {29'd0, done4, done8, done16}, 32'd0);
    chk("reset product", prod16 | {16'd0, prod8} | {24'd0, prod4}, 32'd0);
    chk("reset state", {26'd0, st4, st8, st16}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // directed products
    run_op(8, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, "w8 s -128*-128");
    run_op(8, 1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, "w8 u ff*ff");
    run_op(8, 1'b1, 16'h007F, 16'h0080, 32'h0000_C080, "w8 s 127*-128");
    run_op(8, 1'b0, 16'h0080, 16'h0080, 32'h0000_4000, "w8 u 80*80");
    run_op(8, 1'b0, 16'h00FF, 16'h0001, 32'h0000_00FF, "w8 u ff*01");
    run_op(4, 1'b1, 16'h0008, 16'h0008, 32'h0000_0040, "w4 s -8*-8");
    run_op(4, 1'b0, 16'h000F, 16'h000F, 32'h0000_00E1, "w4 u f*f");
    run_op(4, 1'b1, 16'h0007, 16'h0008, 32'h0000_00C8, "w4 s 7*-8");
    run_op(4, 1'b1, 16'h000F, 16'h000F, 32'h0000_0001, "w4 s -1*-1");
    run_op(16, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "w16 s min*min");
    run_op(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "w16 u max*max");
    run_op(16, 1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, "w16 s -1*1");

    // start held high through DONE; operands change while busy
    @(negedge clk);
    tc_in = 1'b1; a_in = 16'h0007; b_in = 16'h00FD; start_sel = 3'b010;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    a_in = 16'h0005; b_in = 16'h0006;
    while (done8 !== 1'b1 && lat < 64) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("held first latency", 32'(lat), 32'd5);
    chk("held first product", {16'd0, prod8}, 32'h0000_FFEB);
    @(posedge clk);
    @(negedge clk);
    chk("held idle busy", {31'd0, busy8}, 32'd0);
    chk("held idle product", {16'd0, prod8}, 32'h0000_FFEB);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_sel = 3'b000;
    chk("held second busy", {31'd0, busy8}, 32'd1);
    while (done8 !== 1'b1 && lat < 64) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("held second latency", 32'(lat), 32'd5);
    chk("held second product", {16'd0, prod8}, 32'h0000_001E);

    // second start pulsed while busy is ignored
    @(negedge clk);
    tc_in = 1'b1; a_in = 16'h1234; b_in = 16'h0002; start_sel = 3'b100;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_sel = 3'b000;
    busy_ok = (busy16 === 1'b1);
    @(posedge clk);
    lat++;
    @(negedge clk);
    busy_ok &= (busy16 === 1'b1);
    tc_in = 1'b0; a_in = 16'hFFFF; b_in = 16'hFFFF; start_sel = 3'b100;
    @(posedge clk);
    lat++;
    @(negedge clk);
    start_sel = 3'b000;
    while (done16 !== 1'b1 && lat < 64) begin
      busy_ok &= (busy16 === 1'b1);
      @(posedge clk); lat++; @(negedge clk);
    end
    busy_ok &= (busy16 === 1'b1);
    chk("ignore busy steady", {31'd0, busy_ok}, 32'd1);
    chk("ignore latency", 32'(lat), 32'd9);
    chk("ignore product", prod16, 32'h0000_2468);

    // async reset in the third RUN cycle aborts with no done
    @(negedge clk);
    tc_in = 1'b1; a_in = 16'h0011; b_in = 16'h0022; start_sel = 3'b010;
    @(posedge clk);
    @(negedge clk);
    start_sel = 3'b000;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre-abort busy", {31'd0, busy8}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort busy", {31'd0, busy8}, 32'd0);
    chk("abort done", {31'd0, done8}, 32'd0);
    chk("abort product", {16'd0, prod8}, 32'd0);
    chk("abort state", {30'd0, st8}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8 === 1'b1) lat++;
    end
    chk("abort no done", 32'(lat), 32'd0);
    run_op(8, 1'b1, 16'h0003, 16'h0005, 32'h0000_000F, "w8 after reset");

    // short random sweep against the integer reference
    foreach (widths[k]) begin
      for (int t = 0; t < 2; t++) begin
        for (int n = 0; n < 40; n++) begin
          ra = 16'($urandom_range(0, 65535));
          rb = 16'($urandom_range(0, 65535));
          run_op(widths[k], t[0], ra, rb, ref_mult(widths[k], t[0], ra, rb), "sweep");
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_radix4_mult.md
BOOTH_RADIX4_MULT -- requirements
Module: booth_radix4_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port tc, input, 1 bit: 1 = signed two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a, input, WIDTH bits: multiplicand; sampled with start.
REQ-007 SHALL have port b, input, WIDTH bits: multiplier, Booth-recoded; sampled with start.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and DONE states.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse when product is valid.
REQ-010 SHALL have port product, output, 2*WIDTH bits: result; held stable from done until the next accepted start.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after final iteration; DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL, on accepting start, latch a and b extended to WIDTH+2 bits (sign-extended if tc=1, zero-extended if tc=0), clear the accumulator, and set the implicit bit b[-1]=0.
REQ-013 SHALL perform exactly one radix-4 Booth digit per RUN cycle: ITER = WIDTH/2 digits if tc=1, WIDTH/2+1 if tc=0.
REQ-014 SHALL, per digit i, recode triplet (b[2i+1], b[2i], b[2i-1]) into single = b[2i] XOR b[2i-1], double = (b[2i+1] & ~b[2i] & ~b[2i-1]) | (~b[2i+1] & b[2i] & b[2i-1]), negate = b[2i+1].
REQ-015 SHALL select a partial product of 0, +/-A or +/-2A (WIDTH+2 bits, two's complement, negation as invert plus carry-in) and add it to the upper accumulator bits, then shift the accumulator arithmetically right by 2.
REQ-016 SHALL treat negate with single=double=0 (triplet 111) as zero contribution; no spurious carry-in.
REQ-017 SHALL hold an iteration counter of ceil(log2(WIDTH/2+2)) bits, counting from 0; the last digit is processed when counter = ITER-1.
REQ-018 SHALL load product in the RUN->DONE transition; done is high exactly during the DONE cycle; latency from the accepting edge to done high is ITER+1 cycles.
REQ-019 SHALL ignore start while busy=1; latched operands and tc are not disturbed.
REQ-020 SHALL accept a start asserted in the DONE cycle only at the following IDLE cycle, i.e. back-to-back throughput is one result per ITER+2 cycles.
REQ-021 SHALL produce the exact mathematical product for all operand pairs, including most-negative signed values, with no overflow or truncation in 2*WIDTH bits.

Reset
REQ-022 SHALL, on reset=1 at any time including mid-RUN, immediately force state IDLE, busy=0, done=0, product=0, counter=0, accumulator=0.
REQ-023 SHALL, after reset deassertion, accept start on the first rising edge where reset is low.
REQ-024 SHALL NOT emit done for an operation aborted by reset.

Verification
REQ-025 WIDTH=8, tc=1, a=0x80 (-128), b=0x80 -> done 5 cycles after accept, product=0x4000.
REQ-026 WIDTH=8, tc=0, a=0xFF, b=0xFF -> done 6 cycles after accept, product=0xFE01.
REQ-027 WIDTH=8, tc=1, a=0x07, b=0xFD (-3) -> product=0xFFEB (-21); then start held high through DONE -> second op accepted only in next IDLE.
REQ-028 WIDTH=16, tc=1, start with a=0x1234, b=0x0002, second start pulsed with different operands 2 cycles later -> ignored, product=0x00002468, busy stays high throughout.
REQ-029 WIDTH=8, reset asserted asynchronously in 3rd RUN cycle -> busy, done, product drop to 0 without waiting for a clock edge; no done pulse; next op a=0x03, b=0x05, tc=1 -> product=0x000F.
REQ-030 Randomised sweep: WIDTH in {4, 8, 16}, both tc values, 10000 operand pairs each -> product matches reference multiply, done exactly ITER+1 cycles after accept.
